// File: rtl/serial_parallel.sv
// serial_parallel: receive-side deserializer for one PHY lane (clk_32f domain).
// Hunts bit-by-bit for the idle comma, confirms alignment over a run of
// consecutive commas on the 8-bit grid, then delivers one byte per 8 clocks.
//
// Ports:
//   clk_32f     - bit clock, all logic on rising edge
//   reset_L     - asynchronous active-low reset
//   data_in     - serial bit, MSB first
//   data_out    - last completed byte while active, held 8 cycles
//   valid_out   - 1 when data_out is payload (not the comma), held 8 cycles
//   byte_strobe - one-cycle pulse on the edge data_out updates
//   active      - lane aligned and delivering bytes (sticky until reset)
module serial_parallel #(
  parameter logic [7:0]  COMMA    = 8'hBC,
  parameter int unsigned BC_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  localparam int unsigned BcW = $clog2(BC_COUNT + 1);

  typedef enum logic [1:0] {StUnlocked, StAligning, StActive} state_e;

  state_e           state;
  // Only the 7 newest bits are kept; with data_in they form the candidate byte.
  logic [6:0]       sr;
  logic [2:0]       bit_cnt;
  logic [BcW-1:0]   bc_cnt;
  logic [7:0]       w;
  logic             is_comma;
  logic             boundary;

  assign w        = {sr, data_in};
  assign is_comma = (w == COMMA);
  assign boundary = (bit_cnt == 3'd7);

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state       <= StUnlocked;
      sr          <= '0;
      bit_cnt     <= '0;
      bc_cnt      <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
      active      <= 1'b0;
    end else begin
      sr          <= w[6:0];
      bit_cnt     <= bit_cnt + 3'd1;
      byte_strobe <= 1'b0;
      unique case (state)
        StUnlocked: begin
          if (is_comma) begin
            // Restart the byte grid so the next boundary lands 8 bits later.
            bit_cnt <= '0;
            bc_cnt  <= BcW'(1);
            if (BC_COUNT == 1) begin
              state  <= StActive;
              active <= 1'b1;
            end else begin
              state <= StAligning;
            end
          end
        end
        StAligning: begin
          if (boundary) begin
            if (is_comma) begin
              bc_cnt <= bc_cnt + BcW'(1);
              if (bc_cnt == BcW'(BC_COUNT - 1)) begin
                state  <= StActive;
                active <= 1'b1;
              end
            end else begin
              // False lock: the comma did not repeat on the grid.
              bc_cnt <= '0;
              state  <= StUnlocked;
            end
          end
        end
        StActive: begin
          if (boundary) begin
            data_out    <= w;
            valid_out   <= !is_comma;
            byte_strobe <= 1'b1;
          end
        end
        default: state <= StUnlocked;
      endcase
    end
  end

endmodule
